// File: rtl/rr_arb_pkg.sv
// Shared types and limits for the round-robin packet-lock arbiter.
// The optional per-owner packet quota is enabled with RR_ARB_QUOTA_EN.
package rr_arb_pkg;

  localparam int RR_MAX_N     = 32;
  localparam int RR_MAX_QUOTA = 15;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/rr_pri_enc.sv
// LSB-first fixed-priority encoder: lowest set request bit wins.
// Produces the winner as both a one-hot vector and a binary index.
module rr_pri_enc
  import rr_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    onehot_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

  if (N < 2 || N > RR_MAX_N) begin : g_bad_n
    $error("rr_pri_enc: N out of range");
  end

  always_comb begin
    logic found;
    found    = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && !found) begin
        found       = 1'b1;
        onehot_o[i] = 1'b1;
        idx_o       = ID_W'(i);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/rr_arb_lock.sv
// Round-robin arbiter that locks onto the winner until its packet ends.
// Define RR_ARB_QUOTA_EN to let an owner keep priority for up to QUOTA packets.
//
// state  | meaning
// IDLE   | no packet in flight; grant is combinational from req_i and mask_q
// LOCKED | packet (or unaccepted grant) in flight; grant pinned to owner_q
module rr_arb_lock
  import rr_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int ID_W  = $clog2(N),
  parameter int QUOTA = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_i,
  input  logic [N-1:0]    last_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] gnt_id_o
);

  if (N < 2 || N > RR_MAX_N) begin : g_bad_n
    $error("rr_arb_lock: N out of range");
  end
  if (QUOTA < 1 || QUOTA > RR_MAX_QUOTA) begin : g_bad_quota
    $error("rr_arb_lock: QUOTA out of range");
  end

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [N-1:0]    mask_q, mask_d, mask_eff;

  logic [N-1:0]    m_oh, r_oh, win_oh;
  logic [ID_W-1:0] m_idx, r_idx, win_idx;
  logic            m_any, r_any;
  logic            pkt_end;

  function automatic logic [N-1:0] above(input logic [ID_W-1:0] k);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (i > int'(k));
    return m;
  endfunction

`ifdef RR_ARB_QUOTA_EN
  logic [3:0] cnt_q, cnt_d, cnt_base, cnt_inc;
  logic       pend_q, pend_d;
  logic       cancel;

  // A held priority is dropped as soon as the previous owner stops requesting.
  assign cancel   = pend_q && !req_i[owner_q];
  assign mask_eff = cancel ? above(owner_q) : mask_q;
`else
  assign mask_eff = mask_q;
`endif

  rr_pri_enc #(.N(N), .ID_W(ID_W)) u_enc_masked (
    .req_i    (req_i & mask_eff),
    .onehot_o (m_oh),
    .idx_o    (m_idx),
    .any_o    (m_any)
  );

  rr_pri_enc #(.N(N), .ID_W(ID_W)) u_enc_raw (
    .req_i    (req_i),
    .onehot_o (r_oh),
    .idx_o    (r_idx),
    .any_o    (r_any)
  );

  assign win_oh  = m_any ? m_oh  : r_oh;
  assign win_idx = m_any ? m_idx : r_idx;

  always_comb begin
    if (state_q == LOCKED) begin
      gnt_o    = N'(1) << owner_q;
      gnt_id_o = owner_q;
      valid_o  = req_i[owner_q];
    end else begin
      gnt_o    = r_any ? win_oh  : '0;
      gnt_id_o = r_any ? win_idx : '0;
      valid_o  = r_any;
    end
  end

  assign pkt_end = valid_o && ready_i && last_i[gnt_id_o];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    mask_d  = mask_eff;
`ifdef RR_ARB_QUOTA_EN
    pend_d   = 1'b0;
    cnt_d    = cancel ? 4'd0 : cnt_q;
    cnt_base = (state_q == IDLE && win_idx != owner_q) ? 4'd0 : cnt_d;
    cnt_inc  = sat_inc4(cnt_base);
`endif
    case (state_q)
      IDLE: begin
        if (r_any) begin
          owner_d = win_idx;
          if (!pkt_end) begin
            state_d = LOCKED;
`ifdef RR_ARB_QUOTA_EN
            cnt_d = cnt_base;
`endif
          end
        end
      end
      LOCKED: begin
        if (pkt_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pkt_end) begin
`ifdef RR_ARB_QUOTA_EN
      if (cnt_inc < 4'(QUOTA)) begin
        mask_d = mask_eff;
        cnt_d  = cnt_inc;
        pend_d = 1'b1;
      end else begin
        mask_d = above(gnt_id_o);
        cnt_d  = 4'd0;
      end
`else
      mask_d = above(gnt_id_o);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      mask_q  <= '1;
`ifdef RR_ARB_QUOTA_EN
      cnt_q   <= 4'd0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      mask_q  <= mask_d;
`ifdef RR_ARB_QUOTA_EN
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_rr_arb_lock.sv
// Self-checking bench for rr_arb_lock: rotating-pointer reference model feeds a
// per-cycle scoreboard, plus directed checks of the documented scenarios.
module tb_rr_arb_lock;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_i, last_i;
  logic            ready_i;
  logic            valid_o;
  logic [N-1:0]    gnt_o;
  logic [ID_W-1:0] gnt_id_o;

  always #5 clk = ~clk;

  rr_arb_lock #(.N(N), .ID_W(ID_W), .QUOTA(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_i),
    .last_i   (last_i),
    .ready_i  (ready_i),
    .valid_o  (valid_o),
    .gnt_o    (gnt_o),
    .gnt_id_o (gnt_id_o)
  );

  typedef struct packed {
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] id;
    logic            valid;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  bit   m_locked;
  int   m_owner;
  int   m_ptr;

  logic [N-1:0]    obs_gnt;
  logic [ID_W-1:0] obs_id;
  logic            obs_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    e = '0;
    if (m_locked) begin
      e.gnt   = N'(1) << m_owner;
      e.id    = ID_W'(m_owner);
      e.valid = req_i[m_owner];
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (req_i[j]) begin
          e.gnt   = N'(1) << j;
          e.id    = ID_W'(j);
          e.valid = 1'b1;
          break;
        end
      end
    end
    return e;
  endfunction

  task automatic model_step(input exp_t e);
    if (e.valid && ready_i && last_i[e.id]) begin
      m_locked = 1'b0;
      m_ptr    = (int'(e.id) + 1) % N;
    end else if (e.gnt != '0) begin
      m_locked = 1'b1;
      m_owner  = int'(e.id);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
  endtask

  task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] last, input logic rdy);
    exp_t e;
    @(negedge clk);
    req_i   = req;
    last_i  = last;
    ready_i = rdy;
    sb_q.push_back(predict());
    #1;
    obs_gnt   = gnt_o;
    obs_id    = gnt_id_o;
    obs_valid = valid_o;
    e = sb_q.pop_front();
    check("gnt_o",    32'(obs_gnt),   32'(e.gnt));
    check("gnt_id_o", 32'(obs_id),    32'(e.id));
    check("valid_o",  32'(obs_valid), 32'(e.valid));
    model_step(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    req_i   = '0;
    last_i  = '0;
    ready_i = 1'b0;
    model_reset();
    #2;
    check("rst_gnt",   32'(gnt_o),    32'h0);
    check("rst_id",    32'(gnt_id_o), 32'h0);
    check("rst_valid", 32'(valid_o),  32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    req_i   = '0;
    last_i  = '0;
    ready_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    // Mask is all ones during reset, so lowest requester wins immediately.
    req_i = 4'b1100;
    #1;
    check("rst_mask_gnt", 32'(gnt_o), 32'b0100);
    do_reset();

`ifdef RR_ARB_QUOTA_EN
    begin
      int seq_q [6] = '{0, 0, 1, 1, 0, 0};
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        req_i   = 4'b0011;
        last_i  = 4'b0011;
        ready_i = 1'b1;
        #1;
        check("quota_id", 32'(gnt_id_o), 32'(seq_q[i]));
      end
    end
`else
    // Full rotation with single-beat packets.
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 4'b1111, 1'b1);
      check("rr_seq_id", 32'(obs_id), 32'(i % 4));
    end

    // Sticky grant while downstream stalls.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0101, 4'b0101, 1'b0);
      check("stall_gnt", 32'(obs_gnt), 32'b0001);
    end
    cycle(4'b0101, 4'b0101, 1'b1);
    check("stall_end_gnt", 32'(obs_gnt), 32'b0001);
    cycle(4'b0101, 4'b0000, 1'b0);
    check("stall_next_gnt", 32'(obs_gnt), 32'b0100);
    cycle(4'b0100, 4'b0100, 1'b1);

    // Three-beat packet from requester 1 with requester 3 waiting.
    do_reset();
    cycle(4'b1010, 4'b0000, 1'b1);
    check("pkt_b0", 32'(obs_gnt), 32'b0010);
    cycle(4'b1010, 4'b0000, 1'b1);
    check("pkt_b1", 32'(obs_gnt), 32'b0010);
    cycle(4'b1010, 4'b0010, 1'b1);
    check("pkt_b2", 32'(obs_gnt), 32'b0010);
    cycle(4'b1000, 4'b1000, 1'b1);
    check("pkt_next", 32'(obs_gnt), 32'b1000);

    // Mid-packet gap: owner drops req, others churn, lock holds.
    do_reset();
    cycle(4'b1010, 4'b0000, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cycle(4'b1101, 4'b1111, 1'b1);
      check("gap_gnt",   32'(obs_gnt),   32'b0010);
      check("gap_valid", 32'(obs_valid), 32'h0);
    end
    cycle(4'b1010, 4'b0010, 1'b1);
    cycle(4'b1001, 4'b1001, 1'b1);
    check("gap_after", 32'(obs_gnt), 32'b1000);

    // Reset while locked on owner 2 restarts from raw priority.
    do_reset();
    cycle(4'b0100, 4'b0000, 1'b1);
    cycle(4'b0100, 4'b0000, 1'b1);
    check("lock2_gnt", 32'(obs_gnt), 32'b0100);
    do_reset();
    cycle(4'b1100, 4'b1100, 1'b0);
    check("post_rst_gnt", 32'(obs_gnt), 32'b0100);

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r, l;
      r = N'($urandom);
      l = N'($urandom) & N'($urandom);
      cycle(r, l, ($urandom_range(0, 3) != 0));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arb_lock.md
RR_ARB_LOCK -- requirements
Module: rr_arb_lock

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters, legal range 2..32.
REQ-002 SHALL have parameter ID_W, default $clog2(N): width of gnt_id_o.
REQ-003 SHALL have parameter QUOTA, default 2: maximum consecutive packets per owner, legal range 1..15; used only under RR_ARB_QUOTA_EN.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_i  input  N  per-requester valid; bit k means requester k has a beat to send.
REQ-007 SHALL have port last_i  input  N  per-requester last-beat flag; bit k is meaningful only while req_i[k] is high.
REQ-008 SHALL have port ready_i  input  1  downstream accepts the current beat.
REQ-009 SHALL have port valid_o  output  1  a granted beat is presented downstream.
REQ-010 SHALL have port gnt_o  output  N  one-hot grant, or all-zero.
REQ-011 SHALL have port gnt_id_o  output  ID_W  binary index of the granted requester; 0 when gnt_o is zero.

Function
REQ-012 SHALL implement FSM states IDLE and LOCKED, with registers owner_q (ID_W bits) and mask_q (N bits).
REQ-013 In IDLE, winner SHALL be the lowest-index set bit of (req_i & mask_q) if that term is non-zero, else the lowest-index set bit of req_i.
REQ-014 Grant to the winner SHALL be combinational from req_i (zero-cycle latency).
REQ-015 In IDLE with req_i == 0, gnt_o, gnt_id_o and valid_o SHALL be 0.
REQ-016 In LOCKED, gnt_o SHALL equal onehot(owner_q) regardless of other requests.
REQ-017 In LOCKED, valid_o SHALL equal req_i[owner_q].
REQ-018 A beat SHALL be defined as valid_o && ready_i; the packet end is a beat with last_i[granted] = 1.
REQ-019 IDLE->LOCKED SHALL occur when a grant is given and no packet end happens that cycle; owner_q latches the winner. This covers an unaccepted grant (sticky) and a multi-beat packet.
REQ-020 LOCKED->IDLE SHALL occur on a packet end by owner_q.
REQ-021 LOCKED SHALL be held while req_i[owner_q] is low; the arbiter never re-arbitrates mid-packet.
REQ-022 On release by owner k, mask_q SHALL become the bits strictly above k set, which is all-zero for k = N-1 (wrap to raw priority).
REQ-023 A single-beat packet accepted in IDLE SHALL update mask_q and remain in IDLE, so back-to-back grants to different requesters occur on consecutive cycles.
REQ-024 Changes of req_i or last_i on non-owner bits SHALL have no effect in LOCKED.

Reset
REQ-025 While reset is high, state SHALL be IDLE, mask_q all ones, owner_q 0, and the quota counter 0.
REQ-026 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration restarts from lowest-index priority.

Configuration
REQ-027 Macro RR_ARB_QUOTA_EN defined: a saturating counter SHALL count completed packets of the current owner. On release, mask_q SHALL be left unchanged (owner keeps priority) if the count is below QUOTA and req_i[owner] is still high in the cycle after the end. Otherwise mask_q advances per REQ-022 and the counter clears. Any release with mask advance or owner change SHALL clear the counter.
REQ-028 Macro RR_ARB_QUOTA_EN undefined: no counter SHALL exist, QUOTA SHALL be ignored, and mask_q advances on every packet end.

Structure
REQ-029 Package rr_arb_pkg SHALL hold the state enum typedef (IDLE, LOCKED) and the localparam for the maximum N.
REQ-030 Sub-module rr_pri_enc SHALL be a parametrised width-N, LSB-first fixed-priority encoder outputting one-hot plus index. It is instantiated twice, for the masked and raw request vectors.

Verification
REQ-031 Scenario: N=4, req_i=4'b1111, ready_i=1, last_i=4'b1111 for 8 cycles -> gnt_id_o sequence 0,1,2,3,0,1,2,3.
REQ-032 Scenario: req_i=4'b0101, ready_i=0 for 3 cycles, then 1 with last -> gnt_o=4'b0001 held all 4 cycles; next cycle gnt_o=4'b0100.
REQ-033 Scenario: requester 1 sends a 3-beat packet while req_i[3] is high throughout -> gnt_o=4'b0010 for 3 beats, then 4'b1000.
REQ-034 Scenario: mid-packet gap with req_i[1] low for 2 cycles -> valid_o=0 and gnt_o=4'b0010 retained; other requests ignored.
REQ-035 Scenario: reset asserted while LOCKED on owner 2, with req_i=4'b1100 after reset -> first grant is 4'b0100 (mask all ones).
REQ-036 Scenario: with RR_ARB_QUOTA_EN and QUOTA=2, req_i=4'b0011 with single-beat packets -> grant sequence 0,0,1,1,0,0.
